// File: rtl/chimera_cluster_pwr_ctrl.sv
// Register-bus responder that sequences isolation and clock gating for each
// external cluster: isolate, wait for the acknowledge, gate; and the reverse.
module chimera_cluster_pwr_ctrl #(
    parameter int unsigned NumClusters   = 5,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned ResetGated    = 0,
    parameter int unsigned DefaultSettle = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   reg_valid_i,
    input  logic                   reg_write_i,
    input  logic [AddrWidth-1:0]   reg_addr_i,
    input  logic [DataWidth-1:0]   reg_wdata_i,
    input  logic [DataWidth/8-1:0] reg_wstrb_i,
    output logic                   reg_ready_o,
    output logic [DataWidth-1:0]   reg_rdata_o,
    output logic                   reg_error_o,
    input  logic [NumClusters-1:0] isolated_i,
    output logic [NumClusters-1:0] isolate_o,
    output logic [NumClusters-1:0] clk_en_o
);

    localparam logic [NumClusters-1:0] GateReqRst = (ResetGated != 0) ? {NumClusters{1'b1}} : '0;
    localparam logic [7:0]             SettleRst  = 8'(DefaultSettle);

    typedef enum logic {BusIdle, BusResp} busState_e;
    typedef enum logic [2:0] {PwrRun, PwrIso, PwrGated, PwrWake, PwrDeiso} pwrState_e;

    busState_e              busState_q;
    logic                   ready_q;
    logic                   error_q, error_d;
    logic [DataWidth-1:0]   rdata_q, rdata_d;
    logic [NumClusters-1:0] gateReq_q, gateReq_d;
    logic [7:0]             settle_q, settle_d;
    pwrState_e              pwrState_q [NumClusters];
    logic [7:0]             cnt_q      [NumClusters];
    logic [NumClusters-1:0] clkEn_q, isolate_q;
    logic [NumClusters-1:0] gatedVec, busyVec;
    logic [DataWidth-1:0]   wmask;
    logic [9:0]             regIdx;
    logic                   unused_bits;

    assign regIdx      = reg_addr_i[11:2];
    assign unused_bits = ^{reg_addr_i[AddrWidth-1:12], reg_addr_i[1:0], reg_wdata_i, wmask};

    always_comb begin
        gatedVec = '0;
        busyVec  = '0;
        for (int i = 0; i < int'(NumClusters); i++) begin
            gatedVec[i] = (pwrState_q[i] == PwrGated);
            busyVec[i]  = (pwrState_q[i] == PwrIso) || (pwrState_q[i] == PwrWake) ||
                          (pwrState_q[i] == PwrDeiso);
        end
    end

    always_comb begin
        wmask = '0;
        for (int b = 0; b < int'(DataWidth/8); b++) begin
            wmask[b*8 +: 8] = {8{reg_wstrb_i[b]}};
        end
    end

    // Read data reflects register state before any write carried by the same access.
    always_comb begin
        rdata_d   = '0;
        error_d   = 1'b0;
        gateReq_d = gateReq_q;
        settle_d  = settle_q;
        case (regIdx)
            10'd0: begin
                rdata_d[NumClusters-1:0] = gateReq_q;
                if (reg_write_i) begin
                    gateReq_d = (gateReq_q & ~wmask[NumClusters-1:0]) |
                                (reg_wdata_i[NumClusters-1:0] & wmask[NumClusters-1:0]);
                end
            end
            10'd1: begin
                rdata_d[NumClusters-1:0] = gatedVec;
                error_d = reg_write_i;
            end
            10'd2: begin
                rdata_d[NumClusters-1:0] = busyVec;
                error_d = reg_write_i;
            end
            10'd3: begin
                rdata_d[7:0] = settle_q;
                if (reg_write_i && reg_wstrb_i[0]) begin
                    settle_d = reg_wdata_i[7:0];
                end
            end
            default: error_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busState_q <= BusIdle;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
            gateReq_q  <= GateReqRst;
            settle_q   <= SettleRst;
        end else begin
            case (busState_q)
                BusIdle: begin
                    if (reg_valid_i) begin
                        busState_q <= BusResp;
                        ready_q    <= 1'b1;
                        rdata_q    <= rdata_d;
                        error_q    <= error_d;
                        gateReq_q  <= gateReq_d;
                        settle_q   <= settle_d;
                    end
                end
                BusResp: begin
                    busState_q <= BusIdle;
                    ready_q    <= 1'b0;
                    rdata_q    <= '0;
                    error_q    <= 1'b0;
                end
            endcase
        end
    end

    // Each cluster sees the GATE_REQ value from before a same-cycle write.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(NumClusters); i++) begin
            if (rst_i) begin
                pwrState_q[i] <= (ResetGated != 0) ? PwrGated : PwrRun;
                clkEn_q[i]    <= (ResetGated == 0);
                isolate_q[i]  <= (ResetGated != 0);
                cnt_q[i]      <= 8'd0;
            end else begin
                case (pwrState_q[i])
                    PwrRun: begin
                        if (gateReq_q[i]) begin
                            pwrState_q[i] <= PwrIso;
                            isolate_q[i]  <= 1'b1;
                        end
                    end
                    PwrIso: begin
                        if (isolated_i[i]) begin
                            pwrState_q[i] <= PwrGated;
                            clkEn_q[i]    <= 1'b0;
                        end else if (!gateReq_q[i]) begin
                            pwrState_q[i] <= PwrDeiso;
                            isolate_q[i]  <= 1'b0;
                        end
                    end
                    PwrGated: begin
                        if (!gateReq_q[i]) begin
                            pwrState_q[i] <= PwrWake;
                            clkEn_q[i]    <= 1'b1;
                            cnt_q[i]      <= settle_q;
                        end
                    end
                    PwrWake: begin
                        if (cnt_q[i] == 8'd0) begin
                            pwrState_q[i] <= PwrDeiso;
                            isolate_q[i]  <= 1'b0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] - 8'd1;
                        end
                    end
                    PwrDeiso: begin
                        if (!isolated_i[i]) begin
                            pwrState_q[i] <= PwrRun;
                        end
                    end
                    default: begin
                        pwrState_q[i] <= PwrRun;
                        clkEn_q[i]    <= 1'b1;
                        isolate_q[i]  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign reg_ready_o = ready_q;
    assign reg_rdata_o = rdata_q;
    assign reg_error_o = error_q;
    assign clk_en_o    = clkEn_q;
    assign isolate_o   = isolate_q;

endmodule

// File: tb/tb_chimera_cluster_pwr_ctrl.sv
// Self-checking bench for chimera_cluster_pwr_ctrl: directed scenarios plus a
// randomized run checked against a cycle-level behavioural model.
module tb_chimera_cluster_pwr_ctrl;

    localparam int          N    = 5;
    localparam logic [31:0] Base = 32'h3000_1000;
    localparam int ModeRun = 0, ModeIso = 1, ModeGated = 2, ModeWake = 3, ModeDeiso = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          regValid = 1'b0, regWrite = 1'b0;
    logic [31:0]   regAddr = '0, regWdata = '0;
    logic [3:0]    regWstrb = '0;
    logic          regReady, regError;
    logic [31:0]   regRdata;
    logic [N-1:0]  isolated = '0;
    logic [N-1:0]  isolate, clkEn;

    int checks = 0;
    int passes = 0;

    chimera_cluster_pwr_ctrl #(
        .NumClusters(N), .AddrWidth(32), .DataWidth(32), .ResetGated(0), .DefaultSettle(8)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .reg_valid_i(regValid), .reg_write_i(regWrite), .reg_addr_i(regAddr),
        .reg_wdata_i(regWdata), .reg_wstrb_i(regWstrb),
        .reg_ready_o(regReady), .reg_rdata_o(regRdata), .reg_error_o(regError),
        .isolated_i(isolated), .isolate_o(isolate), .clk_en_o(clkEn)
    );

    always #5 clk = ~clk;

    // Reference model: cluster modes with a remaining-wake-cycles count, plus the bus response.
    int           mMode     [N];
    int           mWakeLeft [N];
    logic [N-1:0] mGateReq;
    logic [7:0]   mSettle;
    logic         mReady, mErr, mRespond, mRe;
    logic [31:0]  mRdata, mRv, mVal;
    logic [11:0]  mOff;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mMode[i] = ModeRun;
                mWakeLeft[i] = 0;
            end
            mGateReq = '0; mSettle = 8'd8; mReady = 1'b0; mRdata = '0; mErr = 1'b0;
        end else begin
            mRespond = !mReady && regValid;
            mOff = regAddr[11:0] & 12'hFFC;
            mRv = '0;
            mRe = 1'b0;
            if (mRespond) begin
                case (mOff)
                    12'h000: mRv = 32'(mGateReq);
                    12'h004: for (int i = 0; i < N; i++) mRv[i] = (mMode[i] == ModeGated);
                    12'h008: for (int i = 0; i < N; i++)
                                 mRv[i] = (mMode[i] == ModeIso) || (mMode[i] == ModeWake) || (mMode[i] == ModeDeiso);
                    12'h00C: mRv = 32'(mSettle);
                    default: mRe = 1'b1;
                endcase
                if (regWrite && (mOff == 12'h004 || mOff == 12'h008)) mRe = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                case (mMode[i])
                    ModeRun:   if (mGateReq[i]) mMode[i] = ModeIso;
                    ModeIso:   if (isolated[i]) mMode[i] = ModeGated;
                               else if (!mGateReq[i]) mMode[i] = ModeDeiso;
                    ModeGated: if (!mGateReq[i]) begin
                                   mMode[i] = ModeWake;
                                   mWakeLeft[i] = int'(mSettle) + 1;
                               end
                    ModeWake:  begin
                                   mWakeLeft[i] = mWakeLeft[i] - 1;
                                   if (mWakeLeft[i] == 0) mMode[i] = ModeDeiso;
                               end
                    default:   if (!isolated[i]) mMode[i] = ModeRun;
                endcase
            end
            if (mRespond && regWrite) begin
                if (mOff == 12'h000) begin
                    mVal = 32'(mGateReq);
                    for (int b = 0; b < 4; b++) if (regWstrb[b]) mVal[b*8 +: 8] = regWdata[b*8 +: 8];
                    mGateReq = mVal[N-1:0];
                end else if (mOff == 12'h00C && regWstrb[0]) begin
                    mSettle = regWdata[7:0];
                end
            end
            if (mReady) begin
                mReady = 1'b0; mRdata = '0; mErr = 1'b0;
            end else if (regValid) begin
                mReady = 1'b1; mRdata = mRv; mErr = mRe;
            end
        end
    end

    function automatic logic [N-1:0] expClkEn();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (mMode[i] != ModeGated);
        return r;
    endfunction

    function automatic logic [N-1:0] expIso();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (mMode[i] == ModeIso) || (mMode[i] == ModeGated) || (mMode[i] == ModeWake);
        return r;
    endfunction

    // One bus access; called at a falling edge, returns at the falling edge after the response.
    task automatic applyStimulus(input logic wr, input logic [11:0] off, input logic [31:0] data,
                                 input logic [3:0] strb, output logic rdy, output logic [31:0] rd,
                                 output logic err);
        regValid = 1'b1; regWrite = wr; regAddr = Base + 32'(off); regWdata = data; regWstrb = strb;
        @(negedge clk);
        rdy = regReady; rd = regRdata; err = regError;
        regValid = 1'b0; regWrite = 1'b0; regWstrb = '0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic rdy, err; logic [31:0] rd;
        rst = 1'b1; isolated = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (clkEn !== 5'h1F) $display("[TB] FAIL reset_clk_en: got %h want 1f", clkEn); else passes++;
        checks++; if (isolate !== 5'h00) $display("[TB] FAIL reset_isolate: got %h want 00", isolate); else passes++;
        checks++; if (regReady !== 1'b0) $display("[TB] FAIL reset_ready: got %b want 0", regReady); else passes++;
        applyStimulus(1'b0, 12'h004, '0, '0, rdy, rd, err);
        checks++; if (rdy !== 1'b1) $display("[TB] FAIL reset_read_ready: got %b want 1", rdy); else passes++;
        checks++; if (rd !== 32'h0) $display("[TB] FAIL reset_read_gated: got %h want 0", rd); else passes++;
        checks++; if (err !== 1'b0) $display("[TB] FAIL reset_read_err: got %b want 0", err); else passes++;
        checks++; if (regReady !== 1'b0) $display("[TB] FAIL ready_one_cycle: got %b want 0", regReady); else passes++;
    endtask

    task automatic test_gate_sequence();
        logic rdy, err; logic [31:0] rd;
        applyStimulus(1'b1, 12'h000, 32'h1, 4'hF, rdy, rd, err);
        checks++; if (err !== 1'b0) $display("[TB] FAIL gate_write_err: got %b want 0", err); else passes++;
        checks++; if (isolate[0] !== 1'b1) $display("[TB] FAIL gate_iso_rise: got %b want 1", isolate[0]); else passes++;
        repeat (2) begin
            @(negedge clk);
            checks++; if (clkEn[0] !== 1'b1) $display("[TB] FAIL gate_clk_before_ack: got %b want 1", clkEn[0]); else passes++;
        end
        isolated[0] = 1'b1;
        @(negedge clk);
        checks++; if (clkEn[0] !== 1'b0) $display("[TB] FAIL gate_clk_off: got %b want 0", clkEn[0]); else passes++;
        checks++; if (isolate !== expIso()) $display("[TB] FAIL gate_iso_model: got %h want %h", isolate, expIso()); else passes++;
        applyStimulus(1'b0, 12'h004, '0, '0, rdy, rd, err);
        checks++; if (rd !== 32'h1) $display("[TB] FAIL gate_read_gated: got %h want 1", rd); else passes++;
        applyStimulus(1'b0, 12'h008, '0, '0, rdy, rd, err);
        checks++; if (rd !== 32'h0) $display("[TB] FAIL gate_read_busy: got %h want 0", rd); else passes++;
    endtask

    task automatic test_wake();
        logic rdy, err; logic [31:0] rd;
        applyStimulus(1'b1, 12'h00C, 32'h2, 4'h1, rdy, rd, err);
        applyStimulus(1'b1, 12'h000, 32'h0, 4'hF, rdy, rd, err);
        for (int k = 0; k < 3; k++) begin
            checks++; if ({clkEn[0], isolate[0]} !== 2'b11)
                $display("[TB] FAIL wake_cycle%0d: got clk_en/iso %b want 11", k, {clkEn[0], isolate[0]}); else passes++;
            @(negedge clk);
        end
        checks++; if ({clkEn[0], isolate[0]} !== 2'b10)
            $display("[TB] FAIL wake_deiso: got clk_en/iso %b want 10", {clkEn[0], isolate[0]}); else passes++;
        applyStimulus(1'b0, 12'h008, '0, '0, rdy, rd, err);
        checks++; if (rd !== 32'h1) $display("[TB] FAIL wake_busy_deiso: got %h want 1", rd); else passes++;
        isolated[0] = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 12'h008, '0, '0, rdy, rd, err);
        checks++; if (rd !== 32'h0) $display("[TB] FAIL wake_busy_clear: got %h want 0", rd); else passes++;
        checks++; if (mMode[0] != ModeRun || isolate !== 5'h00)
            $display("[TB] FAIL wake_back_to_run: got iso %h want 00", isolate); else passes++;
    endtask

    task automatic test_abort();
        logic rdy, err; logic [31:0] rd;
        applyStimulus(1'b1, 12'h000, 32'h4, 4'hF, rdy, rd, err);
        checks++; if ({clkEn[2], isolate[2]} !== 2'b11)
            $display("[TB] FAIL abort_iso: got clk_en/iso %b want 11", {clkEn[2], isolate[2]}); else passes++;
        applyStimulus(1'b1, 12'h000, 32'h0, 4'hF, rdy, rd, err);
        checks++; if ({clkEn[2], isolate[2]} !== 2'b10)
            $display("[TB] FAIL abort_deiso: got clk_en/iso %b want 10", {clkEn[2], isolate[2]}); else passes++;
        @(negedge clk);
        checks++; if (clkEn !== 5'h1F) $display("[TB] FAIL abort_clk_en: got %h want 1f", clkEn); else passes++;
        applyStimulus(1'b0, 12'h008, '0, '0, rdy, rd, err);
        checks++; if (rd !== 32'h0) $display("[TB] FAIL abort_busy: got %h want 0", rd); else passes++;
    endtask

    task automatic test_errors();
        logic rdy, err; logic [31:0] rd;
        applyStimulus(1'b0, 12'h040, '0, '0, rdy, rd, err);
        checks++; if ({rdy, err, rd} !== {2'b11, 32'h0})
            $display("[TB] FAIL unmapped_read: got rdy/err %b%b data %h want 11 0", rdy, err, rd); else passes++;
        applyStimulus(1'b1, 12'h004, 32'hFF, 4'hF, rdy, rd, err);
        checks++; if (err !== 1'b1) $display("[TB] FAIL ro_write_err: got %b want 1", err); else passes++;
        applyStimulus(1'b0, 12'h004, '0, '0, rdy, rd, err);
        checks++; if (rd !== 32'h0) $display("[TB] FAIL ro_write_nochange: got %h want 0", rd); else passes++;
        applyStimulus(1'b1, 12'h00C, 32'h55, 4'h0, rdy, rd, err);
        checks++; if (err !== 1'b0) $display("[TB] FAIL zero_strb_err: got %b want 0", err); else passes++;
        applyStimulus(1'b0, 12'h00C, '0, '0, rdy, rd, err);
        checks++; if (rd !== 32'h2) $display("[TB] FAIL zero_strb_settle: got %h want 2", rd); else passes++;
        applyStimulus(1'b1, 12'h000, 32'hFFFF_FFFF, 4'hE, rdy, rd, err);
        applyStimulus(1'b0, 12'h000, '0, '0, rdy, rd, err);
        checks++; if (rd !== 32'h0) $display("[TB] FAIL strb_byte0_masked: got %h want 0", rd); else passes++;
        applyStimulus(1'b1, 12'h010, 32'h1, 4'hF, rdy, rd, err);
        checks++; if (err !== 1'b1) $display("[TB] FAIL unmapped_write_err: got %b want 1", err); else passes++;
    endtask

    task automatic test_reset_mid_wake();
        logic rdy, err; logic [31:0] rd;
        applyStimulus(1'b1, 12'h00C, 32'd10, 4'h1, rdy, rd, err);
        applyStimulus(1'b1, 12'h000, 32'h2, 4'hF, rdy, rd, err);
        isolated[1] = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 12'h000, 32'h0, 4'hF, rdy, rd, err);
        checks++; if (mMode[1] != ModeWake || {clkEn[1], isolate[1]} !== 2'b11)
            $display("[TB] FAIL midwake_reach: got clk_en/iso %b want 11", {clkEn[1], isolate[1]}); else passes++;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (clkEn !== 5'h1F) $display("[TB] FAIL midwake_rst_clk: got %h want 1f", clkEn); else passes++;
        checks++; if (isolate !== 5'h00) $display("[TB] FAIL midwake_rst_iso: got %h want 00", isolate); else passes++;
        rst = 1'b0; isolated = '0;
        applyStimulus(1'b0, 12'h000, '0, '0, rdy, rd, err);
        checks++; if (rd !== 32'h0) $display("[TB] FAIL midwake_rst_gatereq: got %h want 0", rd); else passes++;
        applyStimulus(1'b0, 12'h00C, '0, '0, rdy, rd, err);
        checks++; if (rd !== 32'h8) $display("[TB] FAIL midwake_rst_settle: got %h want 8", rd); else passes++;
    endtask

    task automatic test_random();
        logic [9:0] idx;
        int sel;
        for (int cyc = 0; cyc < 600; cyc++) begin
            checks++; if (clkEn !== expClkEn()) $display("[TB] FAIL rand_clk_en@%0d: got %h want %h", cyc, clkEn, expClkEn()); else passes++;
            checks++; if (isolate !== expIso()) $display("[TB] FAIL rand_iso@%0d: got %h want %h", cyc, isolate, expIso()); else passes++;
            checks++; if (regReady !== mReady) $display("[TB] FAIL rand_ready@%0d: got %b want %b", cyc, regReady, mReady); else passes++;
            if (mReady) begin
                checks++; if ({regError, regRdata} !== {mErr, mRdata})
                    $display("[TB] FAIL rand_resp@%0d: got err %b data %h want err %b data %h", cyc, regError, regRdata, mErr, mRdata); else passes++;
            end
            rst = ($urandom_range(0, 249) == 0);
            for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) isolated[i] = isolate[i];
            if (regValid) begin
                regValid = 1'b0; regWrite = 1'b0; regWstrb = '0;
            end else if (!mReady && $urandom_range(0, 2) == 0) begin
                sel = $urandom_range(0, 9);
                regValid = 1'b1;
                regWrite = (sel <= 4) || (sel == 8 && $urandom_range(0, 1) == 1) || (sel == 9 && $urandom_range(0, 1) == 1);
                regWdata = $urandom;
                regWstrb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                idx = 10'($urandom_range(4, 1023));
                case (sel)
                    5:       regAddr = Base + 32'h0;
                    6:       regAddr = Base + 32'h4;
                    7:       regAddr = Base + 32'h8;
                    8:       begin regAddr = Base + 32'hC; regWdata = 32'($urandom_range(0, 5)); end
                    9:       regAddr = Base + 32'({idx, 2'b00});
                    default: regAddr = Base + 32'($urandom_range(0, 3));
                endcase
            end
            @(negedge clk);
        end
        rst = 1'b0; regValid = 1'b0; regWrite = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_gate_sequence();
        test_wake();
        test_abort();
        test_errors();
        test_reset_mid_wake();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
